// File: rtl/frame_dsp_core.sv
// frame_dsp_core: buffers one frame, optionally applies an in-place boxcar FIR
// or a bit-reversed read order, then streams the frame out under tx_done.
//
// state    | meaning
// IDLE     | waiting for the first sample of a frame
// RECEIVE  | filling the frame buffer
// COMPUTE  | in-place boxcar FIR, one sample per cycle
// TRANSMIT | presenting words until each one is acknowledged
module frame_dsp_core #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 128,
  parameter int TAPS   = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_valid,
  input  logic              tx_done,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid,
  output logic              core_busy,
  output logic              frame_done,
  output logic              drop_err
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RECEIVE  = 2'd1;
  localparam logic [1:0] COMPUTE  = 2'd2;
  localparam logic [1:0] TRANSMIT = 2'd3;

  localparam int TAP_W = $clog2(TAPS);
  localparam int SUM_W = DATA_W + TAP_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [1:0]               state, state_nxt;
  logic [1:0]               mode_q;
  logic [ADDR_W-1:0]        wr_idx, cmp_idx, rd_idx, rd_next;
  logic signed [DATA_W-1:0] buf_mem [DEPTH];
  logic signed [DATA_W-1:0] hist [TAPS];
  logic signed [SUM_W-1:0]  acc, acc_nxt;
  logic signed [DATA_W-1:0] fir_x, fir_y;

  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    r = '0;
    for (int i = 0; i < ADDR_W; i++) r[i] = a[ADDR_W-1-i];
    return r;
  endfunction

  function automatic logic [ADDR_W-1:0] rd_addr(input logic [ADDR_W-1:0] i,
                                                input logic [1:0] m);
    return (m == 2'b10) ? bitrev(i) : i;
  endfunction

  // Running boxcar sum: add the newest sample, drop the one TAPS samples back.
  assign fir_x   = buf_mem[cmp_idx];
  assign acc_nxt = acc + SUM_W'(fir_x) - SUM_W'(hist[TAPS-1]);
  assign fir_y   = DATA_W'(acc_nxt >>> TAP_W);
  assign rd_next = rd_idx + 1'b1;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (data_in_valid) state_nxt = RECEIVE;
      RECEIVE:  if (data_in_valid && wr_idx == LAST)
                  state_nxt = (mode_q == 2'b01) ? COMPUTE : TRANSMIT;
      COMPUTE:  if (cmp_idx == LAST) state_nxt = TRANSMIT;
      TRANSMIT: if (data_out_valid && tx_done && rd_idx == LAST) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Frame storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (rstb) begin
      if (state == IDLE && data_in_valid)         buf_mem[0] <= data_in;
      else if (state == RECEIVE && data_in_valid) buf_mem[wr_idx] <= data_in;
      else if (state == COMPUTE)                  buf_mem[cmp_idx] <= fir_y;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state          <= IDLE;
      mode_q         <= 2'b00;
      wr_idx         <= '0;
      cmp_idx        <= '0;
      rd_idx         <= '0;
      acc            <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      core_busy      <= 1'b0;
      frame_done     <= 1'b0;
      drop_err       <= 1'b0;
      for (int i = 0; i < TAPS; i++) hist[i] <= '0;
    end else begin
      state      <= state_nxt;
      core_busy  <= (state_nxt == COMPUTE) || (state_nxt == TRANSMIT);
      frame_done <= 1'b0;
      if (data_in_valid && core_busy) drop_err <= 1'b1;
      case (state)
        IDLE: begin
          if (data_in_valid) begin
            mode_q <= mode;
            wr_idx <= ADDR_W'(1);
          end
        end
        RECEIVE: begin
          if (data_in_valid) begin
            wr_idx <= wr_idx + 1'b1;
            if (wr_idx == LAST) begin
              cmp_idx <= '0;
              rd_idx  <= '0;
              acc     <= '0;
              for (int i = 0; i < TAPS; i++) hist[i] <= '0;
            end
          end
        end
        COMPUTE: begin
          cmp_idx <= cmp_idx + 1'b1;
          acc     <= acc_nxt;
          hist[0] <= fir_x;
          for (int i = TAPS - 1; i > 0; i--) hist[i] <= hist[i-1];
        end
        TRANSMIT: begin
          if (!data_out_valid) begin
            data_out       <= buf_mem[rd_addr(rd_idx, mode_q)];
            data_out_valid <= 1'b1;
          end else if (tx_done) begin
            if (rd_idx == LAST) begin
              data_out_valid <= 1'b0;
              frame_done     <= 1'b1;
              rd_idx         <= '0;
            end else begin
              rd_idx   <= rd_next;
              data_out <= buf_mem[rd_addr(rd_next, mode_q)];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/frame_dsp_core.md
Name: frame_dsp_core

Overview:
Parametrised frame-processing core, successor to the fixed 16-bit/128-word core. It buffers one frame of DEPTH samples from the receive channel and applies a run-time mode: bypass, boxcar FIR, or bit-reversed reorder (FFT input prep). It then streams the frame to the transmit channel under a tx_done handshake. It sits between the receive deserialiser and the transmit serialiser.

Parameters:
DATA_W, 16, sample width (signed two's complement)
DEPTH, 128, samples per frame; power of two, >= 2
TAPS, 4, boxcar FIR length; power of two, 1..DEPTH
ADDR_W, $clog2(DEPTH), derived; not to be overridden

Ports:
clk  in  1  system clock; all logic on rising edge
rstb  in  1  synchronous reset, active-low
mode  in  2  00 bypass, 01 boxcar FIR, 10 bit-reverse, 11 reserved (treated as bypass)
data_in  in  DATA_W  receive sample
data_in_valid  in  1  sample strobe; one sample per high cycle
tx_done  in  1  transmitter acknowledges current data_out word
data_out  out  DATA_W  transmit sample
data_out_valid  out  1  data_out holds a word awaiting tx_done
core_busy  out  1  high in COMPUTE or TRANSMIT; input not accepted
frame_done  out  1  one-cycle pulse after the last word is acknowledged
drop_err  out  1  sticky: a sample arrived while core_busy

Behaviour:
- Reset is synchronous and active-low. On a clk edge with rstb=0: state=IDLE, all counters 0, data_out=0, data_out_valid=0, core_busy=0, frame_done=0, drop_err=0. The buffer contents are not reset. Reset mid-frame aborts the frame with no frame_done.
- States: IDLE, RECEIVE, COMPUTE, TRANSMIT.
- IDLE:
  - data_in_valid=1 writes buf[0], latches mode into mode_q, sets wr_idx=1, and goes to RECEIVE.
  - The mode input is sampled only at this edge. Changes later in the frame are ignored.
- RECEIVE:
  - Each data_in_valid writes buf[wr_idx] and increments wr_idx.
  - The write of index DEPTH-1 moves to COMPUTE if mode_q=01, otherwise to TRANSMIT.
  - Gaps in data_in_valid are allowed; there is no timeout.
- COMPUTE (FIR only), exactly DEPTH cycles, n = 0..DEPTH-1:
  - Read x[n] and shift it into a TAPS-deep history whose initial contents are zero.
  - Write y[n] = (x[n] + x[n-1] + ... + x[n-TAPS+1]) >>> log2(TAPS) back to buf[n], with x[k<0]=0.
  - Sum width is DATA_W + log2(TAPS), so there is no overflow. The shift is arithmetic (floor, round toward -inf).
  - TAPS=1 gives identity.
  - After n=DEPTH-1, go to TRANSMIT.
- TRANSMIT:
  - On the cycle after entry: data_out = buf[addr(0)] and data_out_valid=1.
  - addr(i) = bit-reverse of i over ADDR_W bits when mode_q=10; otherwise addr(i) = i.
  - tx_done=1 while data_out_valid=1 advances rd_idx. On the next cycle data_out presents the next word and data_out_valid stays high.
  - data_out is stable while valid and not yet acknowledged.
  - tx_done while data_out_valid=0 is ignored.
  - tx_done on word DEPTH-1: next cycle data_out_valid=0, frame_done=1 for one cycle, state=IDLE.
- Latency, last input sample accepted at edge t:
  - bypass/bit-reverse: data_out_valid at t+1 (registered).
  - FIR: data_out_valid at t+DEPTH+1.
- core_busy is registered and equals 1 exactly while state is COMPUTE or TRANSMIT.
- data_in_valid while core_busy=1: sample discarded, drop_err set. drop_err clears only on reset.
- A new frame can start in IDLE on the same cycle frame_done is high (frame_done is high only in IDLE).

Test Plan (DEPTH=8, TAPS=4, DATA_W=16):
1. Bypass: mode=00, inputs 10..17 back-to-back, tx_done every 3rd cycle -> outputs 10..17 in order; data_out stable between acks; frame_done one pulse; core_busy low afterwards.
2. Bit-reverse: mode=10, inputs 0..7 -> outputs 0,4,2,6,1,5,3,7.
3. FIR: mode=01, eight samples of +100 -> 25,50,75,100,100,100,100,100. Eight samples of -4 -> -1,-2,-3,-4,-4,-4,-4,-4. First output valid exactly 9 cycles after the last input.
4. Mode and drop: start a frame with mode=01, switch mode to 10 after sample 2 -> FIR output in natural order. Pulse data_in_valid during TRANSMIT -> drop_err=1, output frame unaffected, drop_err still 1 after the next frame.
5. Reset mid-frame: rstb=0 for 1 cycle after 3 words acknowledged -> next edge data_out_valid=0, core_busy=0, drop_err=0, no frame_done. A following full frame of 1..8 in bypass returns 1..8.
6. Ack edge cases: tx_done held high continuously -> one word per cycle, 8 words, then valid low. tx_done pulsed in IDLE -> no effect.
